// File: rtl/cc_pkg.sv
// cc_pkg: shared widths, FSM states, AXI constants and APB offsets for the cache controller.
package cc_pkg;
  localparam int TAG_W  = 17;
  localparam int IDX_W  = 9;
  localparam int LINE_W = 512;
  localparam int WORD_W = 64;
  localparam logic [1:0] BURST_WRAP = 2'd2;
  localparam logic [2:0] SIZE_8B    = 3'd3;
  localparam logic [3:0] LEN_8      = 4'd7;
  localparam logic [11:0] APB_ID   = 12'h000;
  localparam logic [11:0] APB_HIT  = 12'h004;
  localparam logic [11:0] APB_MISS = 12'h008;
  localparam logic [11:0] APB_CLR  = 12'h00C;
  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG_CHK,
    S_MREQ,
    S_MDATA,
    S_FILL,
    S_SEND
  } state_e;
endpackage

// File: rtl/cc_apb_regs.sv
// cc_apb_regs: zero-wait APB ID/status registers; hit/miss counters exist only with CC_PERF_CNT_EN.
module cc_apb_regs
  import cc_pkg::*;
#(
  parameter logic [31:0] IP_VERSION = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [11:0] paddr_i,
  input  logic        pwrite_i,
  input  logic        hit_i,
  input  logic        miss_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);
  logic rd_en;
  assign pready_o  = psel_i & penable_i;
  assign pslverr_o = 1'b0;
  assign rd_en     = psel_i & ~pwrite_i;
`ifdef CC_PERF_CNT_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;
  logic        clr;
  assign clr    = pready_o & pwrite_i & (paddr_i == APB_CLR);
  assign hit_d  = clr ? '0 : hit_q + 32'(hit_i);
  assign miss_d = clr ? '0 : miss_q + 32'(miss_i);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  assign prdata_o = !rd_en ? '0 :
                    paddr_i == APB_ID   ? IP_VERSION :
                    paddr_i == APB_HIT  ? hit_q :
                    paddr_i == APB_MISS ? miss_q : '0;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, hit_i, miss_i};
  assign prdata_o  = (rd_en && paddr_i == APB_ID) ? IP_VERSION : '0;
`endif
endmodule

// File: rtl/cache_ctrl_top.sv
// cache_ctrl_top: direct-mapped read-only cache between INCT AXI read slave and memory AXI read master.
// Optional hit/miss counters on APB are built in when CC_PERF_CNT_EN is defined.
module cache_ctrl_top
  import cc_pkg::*;
#(
  parameter logic [31:0] IP_VERSION = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [11:0]       paddr_i,
  input  logic              pwrite_i,
  input  logic [31:0]       pwdata_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o,
  input  logic [3:0]        inct_arid_i,
  input  logic [31:0]       inct_araddr_i,
  input  logic [3:0]        inct_arlen_i,
  input  logic [2:0]        inct_arsize_i,
  input  logic [1:0]        inct_arburst_i,
  input  logic              inct_arvalid_i,
  output logic              inct_arready_o,
  output logic [3:0]        inct_rid_o,
  output logic [63:0]       inct_rdata_o,
  output logic [1:0]        inct_rresp_o,
  output logic              inct_rlast_o,
  output logic              inct_rvalid_o,
  input  logic              inct_rready_i,
  output logic [3:0]        mem_arid_o,
  output logic [31:0]       mem_araddr_o,
  output logic [3:0]        mem_arlen_o,
  output logic [2:0]        mem_arsize_o,
  output logic [1:0]        mem_arburst_o,
  output logic              mem_arvalid_o,
  input  logic              mem_arready_i,
  input  logic [3:0]        mem_rid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic [1:0]        mem_rresp_i,
  input  logic              mem_rlast_i,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  output logic              rden_o,
  output logic [IDX_W-1:0]  raddr_o,
  input  logic [TAG_W:0]    rdata_tag_i,
  input  logic [LINE_W-1:0] rdata_data_i,
  output logic              wren_o,
  output logic [IDX_W-1:0]  waddr_o,
  output logic [TAG_W:0]    wdata_tag_o,
  output logic [LINE_W-1:0] wdata_data_o
);
  state_e                 state_q, state_d;
  logic [31:3]            addr_q, addr_d;
  logic [3:0]             id_q, id_d;
  logic [2:0]             beat_q, beat_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [7:0][WORD_W-1:0] line_q, line_d;
  logic [2:0]             word;
  logic                   ar_hs, in_chk, match, in_mreq, in_fill, in_send, unused_ok;
  assign ar_hs   = state_q == S_IDLE && inct_arvalid_i;
  assign in_chk  = state_q == S_TAG_CHK;
  assign in_mreq = state_q == S_MREQ;
  assign in_fill = state_q == S_FILL;
  assign in_send = state_q == S_SEND;
  assign match   = rdata_tag_i == {1'b1, addr_q[31:15]};
  // beat n of a request always maps to line word (offset + n) mod 8, for both fill and send
  assign word    = addr_q[5:3] + beat_q;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      rresp_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      rresp_q <= rresp_d;
      line_q  <= line_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    beat_d  = beat_q;
    rresp_d = rresp_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: if (inct_arvalid_i) begin
        addr_d  = inct_araddr_i[31:3];
        id_d    = inct_arid_i;
        rresp_d = '0;
        state_d = S_TAG_CHK;
      end
      S_TAG_CHK: begin
        if (match) line_d = rdata_data_i;
        beat_d  = '0;
        state_d = match ? S_SEND : S_MREQ;
      end
      S_MREQ: if (mem_arready_i) state_d = S_MDATA;
      S_MDATA: if (mem_rvalid_i) begin
        line_d[word] = mem_rdata_i;
        beat_d       = beat_q + 3'd1;
        if (mem_rresp_i != 2'd0) rresp_d = mem_rresp_i;
        if (mem_rlast_i) state_d = S_FILL;
      end
      S_FILL: begin
        beat_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: if (inct_rready_i) begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign inct_arready_o = state_q == S_IDLE;
  assign rden_o         = ar_hs;
  assign raddr_o        = ar_hs ? inct_araddr_i[14:6] : '0;
  assign mem_arvalid_o  = in_mreq;
  assign mem_araddr_o   = in_mreq ? {addr_q, 3'b000} : '0;
  assign mem_arlen_o    = in_mreq ? LEN_8 : '0;
  assign mem_arsize_o   = in_mreq ? SIZE_8B : '0;
  assign mem_arburst_o  = in_mreq ? BURST_WRAP : '0;
  assign mem_arid_o     = '0;
  assign mem_rready_o   = state_q == S_MDATA;
  assign wren_o         = in_fill;
  assign waddr_o        = in_fill ? addr_q[14:6] : '0;
  assign wdata_tag_o    = in_fill ? {1'b1, addr_q[31:15]} : '0;
  assign wdata_data_o   = in_fill ? line_q : '0;
  assign inct_rvalid_o  = in_send;
  assign inct_rid_o     = in_send ? id_q : '0;
  assign inct_rdata_o   = in_send ? line_q[word] : '0;
  assign inct_rresp_o   = in_send ? rresp_q : '0;
  assign inct_rlast_o   = in_send && beat_q == 3'd7;
  assign unused_ok      = ^{mem_rid_i, inct_arlen_i, inct_arsize_i, inct_arburst_i, inct_araddr_i[2:0], pwdata_i};
  cc_apb_regs #(.IP_VERSION(IP_VERSION)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .paddr_i   (paddr_i),
    .pwrite_i  (pwrite_i),
    .hit_i     (in_chk & match),
    .miss_i    (in_chk & ~match),
    .pready_o  (pready_o),
    .prdata_o  (prdata_o),
    .pslverr_o (pslverr_o)
  );
endmodule

// File: tb/tb_cache_ctrl_top.sv
// tb_cache_ctrl_top: scoreboard bench with SRAM and wrapping-burst memory models around cache_ctrl_top.
module tb_cache_ctrl_top;
  logic clk = 1'b0;
  logic rst_n;
  logic psel_i, penable_i, pwrite_i, pready_o, pslverr_o;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i, prdata_o;
  logic [3:0] inct_arid_i, inct_arlen_i, inct_rid_o;
  logic [31:0] inct_araddr_i;
  logic [2:0] inct_arsize_i;
  logic [1:0] inct_arburst_i, inct_rresp_o;
  logic inct_arvalid_i, inct_arready_o, inct_rlast_o, inct_rvalid_o, inct_rready_i;
  logic [63:0] inct_rdata_o;
  logic [3:0] mem_arid_o, mem_arlen_o, mem_rid_i;
  logic [31:0] mem_araddr_o;
  logic [2:0] mem_arsize_o;
  logic [1:0] mem_arburst_o, mem_rresp_i;
  logic mem_arvalid_o, mem_arready_i, mem_rlast_i, mem_rvalid_i, mem_rready_o;
  logic [63:0] mem_rdata_i;
  logic rden_o, wren_o;
  logic [8:0] raddr_o, waddr_o;
  logic [17:0] rdata_tag_i, wdata_tag_o;
  logic [511:0] rdata_data_i, wdata_data_o;

  cache_ctrl_top dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .inct_arid_i(inct_arid_i), .inct_araddr_i(inct_araddr_i), .inct_arlen_i(inct_arlen_i),
    .inct_arsize_i(inct_arsize_i), .inct_arburst_i(inct_arburst_i), .inct_arvalid_i(inct_arvalid_i),
    .inct_arready_o(inct_arready_o),
    .inct_rid_o(inct_rid_o), .inct_rdata_o(inct_rdata_o), .inct_rresp_o(inct_rresp_o),
    .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i),
    .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o), .mem_arvalid_o(mem_arvalid_o),
    .mem_arready_i(mem_arready_i),
    .mem_rid_i(mem_rid_i), .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i),
    .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .rden_o(rden_o), .raddr_o(raddr_o), .rdata_tag_i(rdata_tag_i), .rdata_data_i(rdata_data_i),
    .wren_o(wren_o), .waddr_o(waddr_o), .wdata_tag_o(wdata_tag_o), .wdata_data_o(wdata_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic        lat;
  } beat_t;
  beat_t exp_q[$];
  beat_t mb;

  int n_vec = 0, n_err = 0;
  int cyc = 0, ar_cyc = 0, ar_cnt = 0, wcnt = 0, beats_seen = 0, beats_in = 0;
  int exp_hits = 0, exp_miss = 0;
  bit bp_en = 0, stall = 0, prev_v = 0;
  logic [1:0] err_resp = 2'd0;
  logic [31:0] cur_addr = '0;
  logic [8:0] last_waddr;
  logic [17:0] last_wtag;
  logic [17:0] tag_mem[512];
  logic [511:0] data_mem[512];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst_n)
    if (rst_n) begin
      for (int i = 0; i < 512; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
      rdata_tag_i  <= '0;
      rdata_data_i <= '0;
    end else begin
      if (rden_o) begin
        rdata_tag_i  <= tag_mem[raddr_o];
        rdata_data_i <= data_mem[raddr_o];
      end
      if (wren_o) begin
        tag_mem[waddr_o]  <= wdata_tag_o;
        data_mem[waddr_o] <= wdata_data_o;
      end
    end

  always @(negedge clk)
    if (!rst_n && wren_o) begin
      wcnt++;
      last_waddr = waddr_o;
      last_wtag  = wdata_tag_o;
    end

  always @(posedge clk) begin
    #2;
    inct_rready_i = bp_en ? ($urandom_range(0, 3) != 0) : !stall;
  end

  initial begin
    logic [31:0] a;
    logic [2:0] w;
    mem_arready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_rresp_i = '0;
    mem_rlast_i = 0; mem_rid_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n && mem_arvalid_o) begin
        ar_cnt++;
        a = mem_araddr_o;
        chk("mem_araddr", mem_araddr_o, {cur_addr[31:3], 3'b000});
        chk("mem_arlen", mem_arlen_o, 4'd7);
        chk("mem_arsize", mem_arsize_o, 3'd3);
        chk("mem_arburst", mem_arburst_o, 2'd2);
        chk("mem_arid", mem_arid_o, 4'd0);
        mem_arready_i = 1;
        @(posedge clk); #1;
        mem_arready_i = 0;
        for (int n = 0; n < 8; n++) begin
          w = a[5:3] + 3'(n);
          mem_rvalid_i = 1;
          mem_rdata_i  = mem_word({a[31:6], w, 3'b000});
          mem_rlast_i  = (n == 7);
          mem_rresp_i  = err_resp;
          mem_rid_i    = 4'(n);
          while (!mem_rready_o && !rst_n) begin @(posedge clk); #1; end
          if (rst_n) break;
          @(posedge clk); #1;
          beats_in++;
        end
        mem_rvalid_i = 0;
        mem_rlast_i  = 0;
      end
    end
  end

  always @(negedge clk)
    if (!rst_n) begin
      if (inct_rvalid_o && !prev_v && exp_q.size() > 0 && exp_q[0].lat)
        chk("hit_latency", 64'(cyc - ar_cyc), 64'd2);
      prev_v = inct_rvalid_o;
      if (inct_rvalid_o) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(inct_rvalid_o), 64'd0);
        else if (inct_rready_i) begin
          mb = exp_q.pop_front();
          chk("rdata", inct_rdata_o, mb.data);
          chk("rid", inct_rid_o, mb.id);
          chk("rresp", inct_rresp_o, mb.resp);
          chk("rlast", inct_rlast_o, mb.last);
          beats_seen++;
        end else chk("stall_rdata", inct_rdata_o, exp_q[0].data);
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timeout, %0d beats still expected", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic apb(input logic [11:0] a, input bit wr, input logic [31:0] wd, output logic [31:0] rd);
    psel_i = 1; penable_i = 0; paddr_i = a; pwrite_i = wr; pwdata_i = wd;
    @(posedge clk); #1;
    penable_i = 1;
    @(negedge clk);
    rd = prdata_o;
    chk("pready", pready_o, 1'b1);
    chk("pslverr", pslverr_o, 1'b0);
    @(posedge clk); #1;
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] id, input bit hit, input bit stl);
    logic [2:0] w;
    int a0, w0, b0;
    a0 = ar_cnt; w0 = wcnt; b0 = beats_seen;
    cur_addr = a;
    for (int n = 0; n < 8; n++) begin
      w = a[5:3] + 3'(n);
      exp_q.push_back('{mem_word({a[31:6], w, 3'b000}), id, hit ? 2'd0 : err_resp, n == 7, hit});
    end
    if (hit) exp_hits++; else exp_miss++;
    chk("arready_idle", inct_arready_o, 1'b1);
    inct_arvalid_i = 1; inct_araddr_i = a; inct_arid_i = id;
    inct_arlen_i = 4'($urandom); inct_arsize_i = 3'($urandom); inct_arburst_i = 2'($urandom);
    ar_cyc = cyc;
    @(posedge clk); #1;
    inct_arvalid_i = 0;
    if (stl) begin
      while (beats_seen - b0 < 3) begin @(posedge clk); #1; end
      stall = 1;
      repeat (5) @(posedge clk);
      #1 stall = 0;
    end
    while (exp_q.size() != 0) begin @(posedge clk); #1; end
    chk("mem_ar_count", 64'(ar_cnt - a0), hit ? 64'd0 : 64'd1);
    chk("sram_wr_count", 64'(wcnt - w0), hit ? 64'd0 : 64'd1);
  endtask

  initial begin
    logic [31:0] r, lines[80];
    int a0, w0, b0;
    rst_n = 1;
    psel_i = 0; penable_i = 0; paddr_i = '0; pwrite_i = 0; pwdata_i = '0;
    inct_arvalid_i = 0; inct_araddr_i = '0; inct_arid_i = '0;
    inct_arlen_i = '0; inct_arsize_i = '0; inct_arburst_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("rst_arready", inct_arready_o, 1'b1);
    chk("rst_rvalid", inct_rvalid_o, 1'b0);
    chk("rst_mem_arvalid", mem_arvalid_o, 1'b0);
    chk("rst_mem_araddr", mem_araddr_o, 32'd0);
    chk("rst_rden", rden_o, 1'b0);
    chk("rst_wren", wren_o, 1'b0);
    chk("rst_rdata", inct_rdata_o, 64'd0);
    @(posedge clk); #1;
    apb(12'h000, 0, 0, r); chk("apb_id", r, 32'h0000_0000);
    apb(12'h004, 0, 0, r); chk("apb_hits_rst", r, 32'd0);
    apb(12'h008, 0, 0, r); chk("apb_miss_rst", r, 32'd0);
    apb(12'h000, 1, 32'hDEAD_BEEF, r);
    apb(12'h000, 0, 0, r); chk("apb_id_after_wr", r, 32'h0000_0000);

    rd(32'h0000_1240, 4'h5, 0, 0);
    chk("fill_waddr", last_waddr, 9'h049);
    chk("fill_wtag", last_wtag, 18'h20000);
    rd(32'h0000_1258, 4'hA, 1, 0);
    rd(32'h0000_9240, 4'h1, 0, 0);
    chk("conflict_waddr", last_waddr, 9'h049);
    chk("conflict_wtag", last_wtag, 18'h20001);
    rd(32'h0000_1240, 4'h2, 0, 0);
    rd(32'h0000_1248, 4'h3, 1, 1);
    err_resp = 2'd2;
    rd(32'h0000_2000, 4'h7, 0, 0);
    err_resp = 2'd0;
    rd(32'h0000_2010, 4'h7, 1, 0);

    bp_en = 1;
    for (int i = 0; i < 80; i++) begin
      lines[i] = {1'b1, 16'($urandom), 9'((i * 37 + 5) % 512), 6'b0};
      rd(lines[i] | {26'd0, 3'($urandom), 3'b000}, 4'($urandom), 0, 0);
    end
    for (int i = 0; i < 800; i++)
      rd(lines[$urandom_range(0, 79)] | {26'd0, 3'($urandom), 3'b000}, 4'($urandom), 1, 0);
    bp_en = 0;

`ifdef CC_PERF_CNT_EN
    apb(12'h004, 0, 0, r); chk("apb_hits", r, 32'(exp_hits));
    apb(12'h008, 0, 0, r); chk("apb_miss", r, 32'(exp_miss));
`else
    apb(12'h004, 0, 0, r); chk("apb_hits", r, 32'd0);
    apb(12'h008, 0, 0, r); chk("apb_miss", r, 32'd0);
`endif
    apb(12'h00C, 1, 0, r);
    apb(12'h004, 0, 0, r); chk("apb_hits_clr", r, 32'd0);
    apb(12'h008, 0, 0, r); chk("apb_miss_clr", r, 32'd0);

    cur_addr = 32'h0000_3000; b0 = beats_in; w0 = wcnt; a0 = ar_cnt;
    inct_arvalid_i = 1; inct_araddr_i = 32'h0000_3000; inct_arid_i = 4'h9;
    @(posedge clk); #1;
    inct_arvalid_i = 0;
    while (beats_in - b0 < 3) begin @(posedge clk); #1; end
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("abort_ar_count", 64'(ar_cnt - a0), 64'd1);
    chk("abort_no_wr", 64'(wcnt - w0), 64'd0);
    chk("abort_arready", inct_arready_o, 1'b1);
    chk("abort_rvalid", inct_rvalid_o, 1'b0);
    chk("abort_mem_rready", mem_rready_o, 1'b0);
    @(posedge clk); #1;
    rd(32'h0000_1240, 4'h4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
